vector_mem_sequencer: RTL

Multi-cycle sequencer for VLD/VST. Takes the effective base address (scalar + sign-extended offset, computed upstream) and performs LANES single-word memory accesses over a req/ack port. For VLD it assembles the words into a 256-bit vector for writeback. For VST it serializes the 256-bit store vector. It holds the pipeline stalled from acceptance until completion.

---
 rtl/vmem_pkg.sv | 19 +
 rtl/vmem_lane_buf.sv | 59 +++++
 rtl/vector_mem_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vmem_pkg.sv
// Shared definitions for the vector memory sequencer and the operand-selection logic.
package vmem_pkg;

  localparam int DEF_LANES  = 16;
  localparam int DEF_WORD_W = 16;
  localparam int DEF_ADDR_W = 16;

  // Opcodes the decoder uses to route VLD/VST into the sequencer and J into flush.
  localparam logic [3:0] VLD = 4'b0100;
  localparam logic [3:0] VST = 4'b0101;
  localparam logic [3:0] J   = 4'b1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } vmem_state_e;

endpackage

// File: rtl/vmem_lane_buf.sv
// Lane register file: assembles load words per lane and serializes a captured store vector.
module vmem_lane_buf
  import vmem_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int WORD_W = DEF_WORD_W,
  parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [LANE_W-1:0]       lane_i,
  input  logic                    ldClear_i,
  input  logic                    ldWe_i,
  input  logic [WORD_W-1:0]       ldWord_i,
  input  logic                    stCapture_i,
  input  logic [LANES*WORD_W-1:0] stVec_i,
  output logic [LANES*WORD_W-1:0] loadVec_o,
  output logic [WORD_W-1:0]       stWord_o
);

  logic [WORD_W-1:0] ldMem_q [LANES];
  logic [WORD_W-1:0] stMem_q [LANES];

  // Clear wins over a lane write so a freshly accepted load never sees stale data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LANES; i++) begin
        ldMem_q[i] <= '0;
      end
    end else if (ldClear_i) begin
      for (int i = 0; i < LANES; i++) begin
        ldMem_q[i] <= '0;
      end
    end else if (ldWe_i) begin
      ldMem_q[lane_i] <= ldWord_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LANES; i++) begin
        stMem_q[i] <= '0;
      end
    end else if (stCapture_i) begin
      for (int i = 0; i < LANES; i++) begin
        stMem_q[i] <= stVec_i[i*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    loadVec_o = '0;
    for (int i = 0; i < LANES; i++) begin
      loadVec_o[i*WORD_W +: WORD_W] = ldMem_q[i];
    end
    stWord_o = stMem_q[lane_i];
  end

endmodule

// File: rtl/vector_mem_sequencer.sv
// VLD/VST sequencer: walks LANES single-word accesses over a req/ack port and
// holds the pipeline until the vector transfer completes.
module vector_mem_sequencer
  import vmem_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int WORD_W = DEF_WORD_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    is_store_i,
  input  logic [ADDR_W-1:0]       base_addr_i,
  input  logic [LANES*WORD_W-1:0] store_data_i,
  input  logic                    flush_i,
  output logic                    stall_o,
  output logic                    done_o,
  output logic [LANES*WORD_W-1:0] load_data_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [WORD_W-1:0]       mem_wdata_o,
  input  logic                    mem_ack_i,
  input  logic [WORD_W-1:0]       mem_rdata_i
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  vmem_state_e       state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              isStore_q, isStore_d;
  logic [ADDR_W-1:0] baseAddr_q, baseAddr_d;

  logic              ldClear;
  logic              ldWe;
  logic              stCapture;
  logic [WORD_W-1:0] stWord;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      isStore_q  <= 1'b0;
      baseAddr_q <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      isStore_q  <= isStore_d;
      baseAddr_q <= baseAddr_d;
    end
  end

  // Flush only aborts loads: a store has already committed beats to memory, so it runs to completion.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    isStore_d   = isStore_q;
    baseAddr_d  = baseAddr_q;
    ldClear     = 1'b0;
    ldWe        = 1'b0;
    stCapture   = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    done_o      = 1'b0;
    stall_o     = 1'b0;

    case (state_q)
      IDLE: begin
        stall_o = start_i;
        if (start_i && !flush_i) begin
          state_d    = ACCESS;
          lane_d     = '0;
          isStore_d  = is_store_i;
          baseAddr_d = base_addr_i;
          stCapture  = 1'b1;
          ldClear    = !is_store_i;
        end
      end

      ACCESS: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = isStore_q;
        mem_addr_o  = baseAddr_q + ADDR_W'(lane_q);
        mem_wdata_o = stWord;
        if (mem_ack_i) begin
          ldWe   = !isStore_q;
          lane_d = lane_q + LANE_W'(1);
          if (flush_i && !isStore_q) begin
            state_d = IDLE;
          end else if (lane_q == LAST_LANE) begin
            state_d = DONE;
          end
        end else if (flush_i && !isStore_q) begin
          state_d = IDLE;
        end
      end

      // The writeback stage consumes done in this same cycle, so stall is already released.
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  vmem_lane_buf #(
    .LANES (LANES),
    .WORD_W(WORD_W),
    .LANE_W(LANE_W)
  ) u_lane_buf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .lane_i     (lane_q),
    .ldClear_i  (ldClear),
    .ldWe_i     (ldWe),
    .ldWord_i   (mem_rdata_i),
    .stCapture_i(stCapture),
    .stVec_i    (store_data_i),
    .loadVec_o  (load_data_o),
    .stWord_o   (stWord)
  );

endmodule
